// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read, busy scoreboard, one-deep output register.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_fetch #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  output logic [4:0]      rf_read_a,
  output logic [4:0]      rf_read_b,
  input  logic [XLEN-1:0] rf_out_a,
  input  logic [XLEN-1:0] rf_out_b,
  input  logic            wb_en,
  input  logic [4:0]      wb_sel,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d;

  logic            haz_a, haz_b, hazard, accept;
  logic [XLEN-1:0] opnd_a, opnd_b;

  assign rf_read_a = in_rs1;
  assign rf_read_b = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic byp_a, byp_b;

  // A writeback landing this cycle both supplies the value and retires the hazard.
  always_comb begin
    byp_a  = wb_en && (wb_sel == in_rs1) && (in_rs1 != 5'd0);
    byp_b  = wb_en && (wb_sel == in_rs2) && (in_rs2 != 5'd0);
    haz_a  = (in_rs1 != 5'd0) && busy_q[in_rs1] && !byp_a;
    haz_b  = (in_rs2 != 5'd0) && busy_q[in_rs2] && !byp_b;
    opnd_a = (in_rs1 == 5'd0) ? '0 : (byp_a ? wb_data : rf_out_a);
    opnd_b = (in_rs2 == 5'd0) ? '0 : (byp_b ? wb_data : rf_out_b);
  end
`else
  always_comb begin
    haz_a  = (in_rs1 != 5'd0) && busy_q[in_rs1];
    haz_b  = (in_rs2 != 5'd0) && busy_q[in_rs2];
    opnd_a = (in_rs1 == 5'd0) ? '0 : rf_out_a;
    opnd_b = (in_rs2 == 5'd0) ? '0 : rf_out_b;
  end
`endif

  assign hazard   = haz_a || haz_b;
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op_a_d      = opnd_a;
      op_b_d      = opnd_b;
      rd_d        = in_rd;
      rd_we_d     = in_rd_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear first so a same-cycle set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && (wb_sel != 5'd0))
      busy_d[wb_sel] = 1'b0;
    if (accept && in_rd_we && (in_rd != 5'd0))
      busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = op_a_q;
  assign out_op_b  = op_b_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a register-file model feeds the DUT, expected bundles are
// queued on every accept and compared on every downstream transfer.
module tb_operand_fetch;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_rd_we;
  logic [4:0]      rf_read_a, rf_read_b;
  logic [XLEN-1:0] rf_out_a, rf_out_b;
  logic            wb_en;
  logic [4:0]      wb_sel;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_op_a, out_op_b;
  logic [4:0]      out_rd;
  logic            out_rd_we;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [XLEN-1:0] rf [32];
  logic            rf_load;

  operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_read_a(rf_read_a), .rf_read_b(rf_read_b),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  // Register file model: x0 reads zero, writes land on the rising edge.
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'hA000 + 64'(i);
    end else if (wb_en && wb_sel != 5'd0) begin
      rf[wb_sel] <= wb_data;
    end
  end
  assign rf_out_a = (rf_read_a == 5'd0) ? '0 : rf[rf_read_a];
  assign rf_out_b = (rf_read_b == 5'd0) ? '0 : rf[rf_read_b];

  function automatic logic [XLEN-1:0] exp_op(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wb_en && wb_sel == rs) return wb_data;
`endif
    return rf[rs];
  endfunction

  // Pop on downstream transfer, push on upstream accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_underflow: got bundle a=%h b=%h rd=%0d with nothing expected",
                   out_op_a, out_op_b, out_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({out_op_a, out_op_b, out_rd, out_rd_we} !== e) begin
            n_bad++;
            $display("FAIL sb_bundle: got a=%h b=%h rd=%0d we=%b, want a=%h b=%h rd=%0d we=%b",
                     out_op_a, out_op_b, out_rd, out_rd_we, e.a, e.b, e.rd, e.we);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{a: exp_op(in_rs1), b: exp_op(in_rs2), rd: in_rd, we: in_rd_we});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rf_load = 1'b1; out_ready = 1'b1;
    idle_inputs();
    #3;
    n_cmp++;
    if ({out_valid, out_op_a, out_op_b, out_rd, out_rd_we} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got v=%b a=%h b=%h rd=%0d we=%b, want all 0",
               out_valid, out_op_a, out_op_b, out_rd, out_rd_we);
    end
    step();
    rf_load = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    step(); wb_en = 1'b1; wb_sel = 5'd3; wb_data = 64'h11;
    step(); wb_sel = 5'd4; wb_data = 64'h22;
    step(); wb_en = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd0; in_rd_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    step(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_op_a !== 64'h11 || out_op_b !== 64'h22) begin
      n_bad++;
      $display("FAIL basic_ops: got v=%b a=%h b=%h want v=1 a=11 b=22", out_valid, out_op_a, out_op_b);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_hazard();
    step(); in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd5; in_rd_we = 1'b1;
    step(); in_rs1 = 5'd5; in_rd = 5'd0; in_rd_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_stall%0d: got %b want 0", k, in_ready); end
      step();
    end
    wb_en = 1'b1; wb_sel = 5'd5; wb_data = 64'hABCD;
    @(negedge clk);
    n_cmp++;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_wb_cycle: got %b want 1", in_ready); end
    step(); wb_en = 1'b0; in_valid = 1'b0;
`else
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_wb_cycle: got %b want 0", in_ready); end
    step(); wb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hazard_release: got %b want 1", in_ready); end
    step(); in_valid = 1'b0;
`endif
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_op_a !== 64'hABCD) begin
      n_bad++;
      $display("FAIL hazard_op: got v=%b a=%h want v=1 a=abcd", out_valid, out_op_a);
    end
  endtask

  task automatic test_x0();
    step(); in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0;
    wb_en = 1'b1; wb_sel = 5'd0; wb_data = 64'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", in_ready); end
    step(); in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_op_a !== '0 || dut.busy_q[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_op: got a=%h busy0=%b want a=0 busy0=0", out_op_a, dut.busy_q[0]);
    end
  endtask

  task automatic test_backpressure();
    step(); in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd0; in_rd_we = 1'b0;
    step(); out_ready = 1'b0; in_rs1 = 5'd6; in_rs2 = 5'd8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op_a !== 64'hA001 || out_op_b !== 64'hA002) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h b=%h want rdy=0 v=1 a=a001 b=a002",
                 k, in_ready, out_valid, out_op_a, out_op_b);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_rs1 = 5'(10 + k); in_rs2 = 5'(20 + k);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_resume%0d: got rdy=%b v=%b want 1 1", k, in_ready, out_valid);
      end
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_set_clear();
    step(); in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd7; in_rd_we = 1'b1;
    wb_en = 1'b1; wb_sel = 5'd7; wb_data = 64'h77;
    step(); in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.busy_q[7] !== 1'b1) begin n_bad++; $display("FAIL setclr_set: got busy7=%b want 1", dut.busy_q[7]); end
    step(); wb_en = 1'b1; wb_sel = 5'd7; wb_data = 64'h7777;
    step(); wb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.busy_q[7] !== 1'b0) begin n_bad++; $display("FAIL setclr_clr: got busy7=%b want 0", dut.busy_q[7]); end
  endtask

  task automatic test_async_reset();
    step(); in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd9; in_rd_we = 1'b1; out_ready = 1'b0;
    step(); in_valid = 1'b0; in_rd_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || dut.busy_q[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got v=%b busy9=%b want 1 1", out_valid, dut.busy_q[9]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || dut.busy_q !== '0 || out_rd !== '0 || out_rd_we !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_clear: got v=%b busy=%h rd=%0d we=%b want all 0", out_valid, dut.busy_q, out_rd, out_rd_we);
    end
    sb.delete();
    step(); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1    = 5'($urandom_range(0, 31));
      in_rs2    = 5'($urandom_range(0, 31));
      in_rd     = 5'($urandom_range(0, 31));
      in_rd_we  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_sel    = 5'($urandom_range(0, 31));
      wb_data   = {$urandom, $urandom};
    end
    step(); idle_inputs(); out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: got pending=%0d v=%b want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_x0();
    test_backpressure();
    test_set_clear();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and writeback data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count (5-bit index).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream decoded instruction valid.
REQ-006 SHALL have port in_ready  output  1  upstream transfer accepted when in_valid && in_ready.
REQ-007 SHALL have port in_rs1 / in_rs2  input  5  source register indices.
REQ-008 SHALL have port in_rd  input  5  destination register index.
REQ-009 SHALL have port in_rd_we  input  1  instruction writes in_rd.
REQ-010 SHALL have port rf_read_a / rf_read_b  output  5  register file read selects.
REQ-011 SHALL have port rf_out_a / rf_out_b  input  XLEN  register file read data (combinational, x0 reads 0).
REQ-012 SHALL have port wb_en  input  1  writeback write strobe (same strobe drives register file write_en).
REQ-013 SHALL have port wb_sel  input  5  writeback destination index.
REQ-014 SHALL have port wb_data  input  XLEN  writeback data.
REQ-015 SHALL have port out_valid  output  1  operand bundle valid downstream.
REQ-016 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-017 SHALL have port out_op_a / out_op_b  output  XLEN  registered operands for rs1 / rs2.
REQ-018 SHALL have port out_rd / out_rd_we  output  5 / 1  registered destination info.

Function
REQ-019 SHALL drive rf_read_a = in_rs1 and rf_read_b = in_rs2 combinationally.
REQ-020 SHALL keep scoreboard busy[NREG-1:0]; busy[0] SHALL always read 0.
REQ-021 SHALL flag hazard when (rs!=0 && busy[rs]) for rs1 or rs2, unless resolved by bypass (REQ-026).
REQ-022 SHALL drive in_ready = (!out_valid || out_ready) && !hazard.
REQ-023 SHALL, on accept, register operands, in_rd, in_rd_we into output stage and set out_valid next cycle (1-cycle latency).
REQ-024 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid on out_ready when no new accept in same cycle; back-to-back accepts sustain 1 per cycle.
REQ-026 SHALL select wb_data instead of rf_out_x when wb_en && wb_sel==rs && rs!=0 (bypass, macro-dependent, see REQ-033).
REQ-027 SHALL force operand to 0 when rs==0 regardless of wb_en/wb_sel.
REQ-028 SHALL set busy[in_rd] on accept when in_rd_we && in_rd!=0.
REQ-029 SHALL clear busy[wb_sel] when wb_en && wb_sel!=0.
REQ-030 SHALL give set priority over clear when accept sets and writeback clears the same index in one cycle.
REQ-031 SHALL ignore wb_en to a non-busy register for scoreboard (no underflow; stays 0).

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear busy to 0, out_valid to 0, out_op_a/out_op_b to 0, out_rd to 0, out_rd_we to 0; a held bundle is dropped and in_ready is 1 on first edge after release.

Configuration
REQ-033 SHALL, with OPERAND_FETCH_BYPASS_EN defined, implement REQ-026; a same-cycle writeback resolves the hazard and the operand takes wb_data.
REQ-034 SHALL, without OPERAND_FETCH_BYPASS_EN, omit bypass muxes; hazard persists until busy clears, the instruction accepts the cycle after writeback and the operand comes from rf_out_x.

Verification
REQ-035 SHALL cover: reset, rs1=3 rs2=4, rf returns 0x11/0x22, out_ready=1 -> next cycle out_valid=1, op_a=0x11, op_b=0x22.
REQ-036 SHALL cover: accept rd=5 we=1, then rs1=5 -> in_ready=0 until wb_en sel=5 data=0xABCD; bypass build: accepted that cycle op_a=0xABCD; non-bypass: accepted next cycle.
REQ-037 SHALL cover: rs1=0 with wb_en sel=0 data=0xFFFF -> op_a=0, busy[0]=0, no stall.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged, then out_ready=1 -> one transfer per cycle resumes.
REQ-039 SHALL cover: accept rd=7 we=1 same cycle as wb_en sel=7 -> busy[7]=1 afterward.
REQ-040 SHALL cover: rst_n low while out_valid=1 and busy[9]=1 -> out_valid=0, busy=0 immediately, no clock required.
